match_ctrl: RTL and testbench

- Game-control stage directly upstream of the 6x6 LED grid driver in the memory-match game.
- Accepts the select pulse and cursor position, and reads card values from a synchronous card-value memory.
- Captures the first and second picks and compares their values.
- Produces the active-low found-pair strobe and pick positions that the grid driver consumes, plus the pair, try and game-over status.

---
 rtl/match_ctrl.sv | 176 +++++++++++++++++
 tb/tb_match_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_ctrl.sv
// Memory-match game control: two picks, value compare, found/miss handling.
// Optional MISS_LIMIT_EN ends the game after MAX_MISSES mismatched pairs.
module match_ctrl #(
  parameter int CELLS       = 36,
  parameter int POS_W       = 6,
  parameter int VAL_W       = 5,
  parameter int HOLD_CYCLES = 25000000,
  parameter int TRY_W       = 8,
  parameter int MAX_MISSES  = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sel_pulse,
  input  logic [POS_W-1:0] cursor,
  output logic [POS_W-1:0] mem_addr,
  input  logic [VAL_W-1:0] mem_rdata,
  output logic [POS_W-1:0] card1_pos,
  output logic [POS_W-1:0] card2_pos,
  output logic             card1_valid,
  output logic             card2_valid,
  output logic             found_n,
  output logic [CELLS-1:0] found_map,
  output logic [POS_W-1:0] pairs_found,
  output logic [TRY_W-1:0] tries,
  output logic             busy,
  output logic             game_over
);

  localparam int MAP_W = 2 ** POS_W;
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [POS_W:0] CELLS_X = (POS_W + 1)'(CELLS);
  localparam logic [POS_W-1:0] HALF = POS_W'(CELLS / 2);

  typedef enum logic [3:0] {
    IDLE, FETCH1, CAPT1, WAIT2, FETCH2, CAPT2, MATCH, MISS, DONE
  } state_t;

  state_t state, state_d;

  logic [POS_W-1:0] addr_d, c1_d, c2_d, pairs_d;
  logic             v1_d, v2_d, fn_d;
  logic [CELLS-1:0] map_d, hit;
  logic [TRY_W-1:0] tries_d;
  logic [VAL_W-1:0] val1, val1_d;
  logic [TW-1:0]    timer, timer_d;
  logic [MAP_W-1:0] map_ext;
  logic             legal;

`ifdef MISS_LIMIT_EN
  localparam int MW = $clog2(MAX_MISSES + 1);
  logic [MW-1:0] misses, misses_d;
`endif

  // zero-extended map lets any cursor value index safely
  assign map_ext = MAP_W'(found_map);
  assign legal = sel_pulse && ({1'b0, cursor} < CELLS_X)
                 && !map_ext[cursor];
  assign hit = (CELLS'(1) << card1_pos) | (CELLS'(1) << card2_pos);

  assign busy = (state != IDLE) && (state != WAIT2);
  assign game_over = (state == DONE);

  always_comb begin
    state_d = state;
    addr_d  = mem_addr;
    c1_d    = card1_pos;
    c2_d    = card2_pos;
    v1_d    = card1_valid;
    v2_d    = card2_valid;
    fn_d    = 1'b1;
    map_d   = found_map;
    pairs_d = pairs_found;
    tries_d = tries;
    val1_d  = val1;
    timer_d = timer;
`ifdef MISS_LIMIT_EN
    misses_d = misses;
`endif
    unique case (state)
      IDLE: begin
        if (legal) begin
          c1_d    = cursor;
          addr_d  = cursor;
          v1_d    = 1'b1;
          state_d = FETCH1;
        end
      end
      FETCH1: state_d = CAPT1;
      CAPT1: begin
        val1_d  = mem_rdata;
        state_d = WAIT2;
      end
      WAIT2: begin
        if (legal && cursor != card1_pos) begin
          c2_d    = cursor;
          addr_d  = cursor;
          v2_d    = 1'b1;
          state_d = FETCH2;
        end
      end
      FETCH2: state_d = CAPT2;
      CAPT2: begin
        if (tries != '1) tries_d = tries + 1'b1;
        if (mem_rdata == val1) begin
          fn_d    = 1'b0;
          map_d   = found_map | hit;
          pairs_d = pairs_found + 1'b1;
          state_d = MATCH;
        end else begin
          timer_d = TW'(HOLD_CYCLES - 1);
`ifdef MISS_LIMIT_EN
          misses_d = misses + 1'b1;
`endif
          state_d = MISS;
        end
      end
      MATCH: begin
        v1_d    = 1'b0;
        v2_d    = 1'b0;
        state_d = (pairs_found == HALF) ? DONE : IDLE;
      end
      MISS: begin
        if (timer == '0) begin
          v1_d    = 1'b0;
          v2_d    = 1'b0;
`ifdef MISS_LIMIT_EN
          state_d = (misses == MW'(MAX_MISSES)) ? DONE : IDLE;
`else
          state_d = IDLE;
`endif
        end else begin
          timer_d = timer - 1'b1;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      mem_addr    <= '0;
      card1_pos   <= '0;
      card2_pos   <= '0;
      card1_valid <= 1'b0;
      card2_valid <= 1'b0;
      found_n     <= 1'b1;
      found_map   <= '0;
      pairs_found <= '0;
      tries       <= '0;
      val1        <= '0;
      timer       <= '0;
`ifdef MISS_LIMIT_EN
      misses      <= '0;
`endif
    end else begin
      state       <= state_d;
      mem_addr    <= addr_d;
      card1_pos   <= c1_d;
      card2_pos   <= c2_d;
      card1_valid <= v1_d;
      card2_valid <= v2_d;
      found_n     <= fn_d;
      found_map   <= map_d;
      pairs_found <= pairs_d;
      tries       <= tries_d;
      val1        <= val1_d;
      timer       <= timer_d;
`ifdef MISS_LIMIT_EN
      misses      <= misses_d;
`endif
    end
  end

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: synchronous card memory model plus found-pair
// scoreboard; MISS_LIMIT_EN adds the miss-limit scenario.
module tb_match_ctrl;

  localparam int CELLS = 36;
  localparam int POS_W = 6;
  localparam int VAL_W = 5;
  localparam int HOLD  = 8;
  localparam int TRY_W = 8;

  logic             clock;
  logic             reset_n;
  logic             sel_pulse;
  logic [POS_W-1:0] cursor;
  logic [POS_W-1:0] mem_addr;
  logic [VAL_W-1:0] mem_rdata;
  logic [POS_W-1:0] card1_pos;
  logic [POS_W-1:0] card2_pos;
  logic             card1_valid;
  logic             card2_valid;
  logic             found_n;
  logic [CELLS-1:0] found_map;
  logic [POS_W-1:0] pairs_found;
  logic [TRY_W-1:0] tries;
  logic             busy;
  logic             game_over;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [POS_W-1:0] p1;
    logic [POS_W-1:0] p2;
  } exp_t;
  exp_t exp_q[$];

  logic [VAL_W-1:0] mem [64];
  logic prev_low;

  match_ctrl #(
    .CELLS(CELLS), .POS_W(POS_W), .VAL_W(VAL_W),
    .HOLD_CYCLES(HOLD), .TRY_W(TRY_W), .MAX_MISSES(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .sel_pulse(sel_pulse),
    .cursor(cursor), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .card1_pos(card1_pos), .card2_pos(card2_pos),
    .card1_valid(card1_valid), .card2_valid(card2_valid),
    .found_n(found_n), .found_map(found_map),
    .pairs_found(pairs_found), .tries(tries),
    .busy(busy), .game_over(game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) mem_rdata <= mem[mem_addr];

  // scoreboard consumer: each found pulse pops one expected pair
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_low = 1'b0;
    end else begin
      if (found_n === 1'b0) begin
        checks++;
        if (prev_low) begin
          errors++;
          $display("FAIL found_width: found_n low two cycles in a row");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL found_unexpected: pulse at pos %0d/%0d, none expected",
                   card1_pos, card2_pos);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({card1_pos, card2_pos, card1_valid, card2_valid} !==
              {e.p1, e.p2, 2'b11}) begin
            errors++;
            $display("FAIL found_pair: got %0d/%0d v=%b%b expected %0d/%0d v=11",
                     card1_pos, card2_pos, card1_valid, card2_valid,
                     e.p1, e.p2);
          end
        end
      end
      prev_low = (found_n === 1'b0);
    end
  end

  task automatic do_reset();
    sel_pulse = 1'b0;
    cursor = '0;
    reset_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic pick(input int p);
    cursor = POS_W'(p);
    sel_pulse = 1'b1;
    @(negedge clock);
    sel_pulse = 1'b0;
  endtask

  task automatic pair(input int a, input int b, input bit match);
    pick(a);
    repeat (2) @(negedge clock);
    if (match) exp_q.push_back('{POS_W'(a), POS_W'(b)});
    pick(b);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_addr, card1_pos, card2_pos, card1_valid, card2_valid, found_n,
         found_map, pairs_found, tries, busy, game_over} !==
        {6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 36'd0, 6'd0, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: outputs not at reset values");
    end
    mem[3] = 5'd7;
    mem[20] = 5'd7;
    mem[0] = 5'd1;
    mem[1] = 5'd2;
    mem[4] = 5'd11;
    pick(4);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_addr, card1_valid, busy} !== {6'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_fetch: addr=%0d v1=%b busy=%b expected 0/0/0",
               mem_addr, card1_valid, busy);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    pair(3, 20, 1'b1);
    repeat (3) @(negedge clock);
    pair(0, 1, 1'b0);
    repeat (5) @(negedge clock);
    checks++;
    if (found_map === '0) begin
      errors++;
      $display("FAIL reset_setup: found_map empty before reset");
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({card1_valid, card2_valid, found_map, pairs_found, tries, busy,
         game_over, found_n} !==
        {1'b0, 1'b0, 36'd0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_miss: map=%h pairs=%0d tries=%0d busy=%b expected 0/0/0/0",
               found_map, pairs_found, tries, busy);
    end
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_match();
    do_reset();
    mem[3] = 5'd7;
    mem[20] = 5'd7;
    pick(3);
    checks++;
    if ({card1_valid, card1_pos, mem_addr} !== {1'b1, 6'd3, 6'd3}) begin
      errors++;
      $display("FAIL match_pick1: v1=%b pos=%0d addr=%0d expected 1/3/3",
               card1_valid, card1_pos, mem_addr);
    end
    repeat (2) @(negedge clock);
    exp_q.push_back('{6'd3, 6'd20});
    pick(20);
    @(negedge clock);
    checks++;
    if (found_n !== 1'b1) begin
      errors++;
      $display("FAIL match_early: found_n=%b expected 1", found_n);
    end
    @(negedge clock);
    checks++;
    if (found_n !== 1'b0) begin
      errors++;
      $display("FAIL match_latency: found_n=%b expected 0", found_n);
    end
    @(negedge clock);
    checks++;
    if ({found_n, card1_valid, card2_valid} !== 3'b100) begin
      errors++;
      $display("FAIL match_after: fn/v1/v2=%b%b%b expected 100",
               found_n, card1_valid, card2_valid);
    end
    checks++;
    if ({found_map[3], found_map[20], pairs_found, tries, card1_pos,
         card2_pos, busy} !== {2'b11, 6'd1, 8'd1, 6'd3, 6'd20, 1'b0}) begin
      errors++;
      $display("FAIL match_status: map3/20=%b%b pairs=%0d tries=%0d pos=%0d/%0d expected 11/1/1/3/20",
               found_map[3], found_map[20], pairs_found, tries,
               card1_pos, card2_pos);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL match_missing: %0d pulses outstanding expected 0",
               exp_q.size());
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    mem[0] = 5'd1;
    mem[1] = 5'd2;
    mem[2] = 5'd2;
    pair(0, 1, 1'b0);
    @(negedge clock);
    for (int i = 0; i < HOLD; i++) begin
      cursor = 6'd2;
      sel_pulse = (i == 3);
      @(negedge clock);
      checks++;
      if ({card1_valid, card2_valid, found_n, busy} !== 4'b1111) begin
        errors++;
        $display("FAIL miss_hold[%0d]: v1/v2/fn/busy=%b%b%b%b expected 1111",
                 i, card1_valid, card2_valid, found_n, busy);
      end
    end
    sel_pulse = 1'b0;
    @(negedge clock);
    checks++;
    if ({card1_valid, card2_valid, busy, card1_pos, card2_pos, tries,
         found_map, game_over} !==
        {3'b000, 6'd0, 6'd1, 8'd1, 36'd0, 1'b0}) begin
      errors++;
      $display("FAIL miss_exit: v1/v2/busy=%b%b%b pos=%0d/%0d tries=%0d map=%h expected 000/0/1/1/0",
               card1_valid, card2_valid, busy, card1_pos, card2_pos,
               tries, found_map);
    end
  endtask

  task automatic test_illegal();
    int bad[3];
    bad = '{36, 45, 63};
    do_reset();
    mem[5] = 5'd9;
    mem[6] = 5'd9;
    foreach (bad[k]) begin
      pick(bad[k]);
      checks++;
      if ({card1_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL illegal_pos[%0d]: v1/busy=%b%b expected 00",
                 bad[k], card1_valid, busy);
      end
    end
    pick(5);
    repeat (2) @(negedge clock);
    pick(5);
    pick(40);
    @(negedge clock);
    checks++;
    if ({card1_valid, card2_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL illegal_repick: v1/v2/busy=%b%b%b expected 100",
               card1_valid, card2_valid, busy);
    end
    exp_q.push_back('{6'd5, 6'd6});
    pick(6);
    repeat (3) @(negedge clock);
    pick(5);
    pick(6);
    checks++;
    if ({card1_valid, busy, pairs_found, tries} !== {2'b00, 6'd1, 8'd1}) begin
      errors++;
      $display("FAIL illegal_found: v1/busy=%b%b pairs=%0d tries=%0d expected 00/1/1",
               card1_valid, busy, pairs_found, tries);
    end
  endtask

  task automatic test_full_game();
    do_reset();
    for (int i = 0; i < CELLS; i++) mem[i] = VAL_W'(i / 2);
    for (int k = 0; k < CELLS / 2; k++) begin
      pair(2 * k, 2 * k + 1, 1'b1);
      repeat (3) @(negedge clock);
    end
    checks++;
    if ({pairs_found, tries, found_map, game_over, busy} !==
        {6'd18, 8'd18, {CELLS{1'b1}}, 2'b11}) begin
      errors++;
      $display("FAIL full_game: pairs=%0d tries=%0d map=%h over=%b expected 18/18/all/1",
               pairs_found, tries, found_map, game_over);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_missing: %0d pulses outstanding expected 0",
               exp_q.size());
    end
    pick(7);
    pick(50);
    repeat (3) @(negedge clock);
    checks++;
    if ({game_over, card1_valid, tries, found_n} !== {2'b10, 8'd18, 1'b1}) begin
      errors++;
      $display("FAIL full_locked: over/v1=%b%b tries=%0d expected 10/18",
               game_over, card1_valid, tries);
    end
  endtask

`ifdef MISS_LIMIT_EN
  task automatic test_miss_limit();
    do_reset();
    mem[0] = 5'd1;
    mem[1] = 5'd2;
    mem[2] = 5'd3;
    mem[3] = 5'd4;
    pair(0, 1, 1'b0);
    repeat (2 + HOLD) @(negedge clock);
    checks++;
    if ({game_over, busy} !== 2'b00) begin
      errors++;
      $display("FAIL limit_first: over/busy=%b%b expected 00",
               game_over, busy);
    end
    pair(2, 3, 1'b0);
    repeat (2 + HOLD) @(negedge clock);
    checks++;
    if ({game_over, card1_valid, card2_valid, pairs_found, tries} !==
        {3'b100, 6'd0, 8'd2}) begin
      errors++;
      $display("FAIL limit_done: over/v1/v2=%b%b%b pairs=%0d tries=%0d expected 100/0/2",
               game_over, card1_valid, card2_valid, pairs_found, tries);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = VAL_W'(i + 16);
    reset_n = 1'b0;
    sel_pulse = 1'b0;
    cursor = '0;
    prev_low = 1'b0;
    test_reset();
    test_match();
    test_mismatch();
    test_illegal();
    test_full_game();
`ifdef MISS_LIMIT_EN
    test_miss_limit();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
